// File: rtl/mem_arbitro_if.sv
// mem_arbitro_if: one requester port of the memory arbiter (request fields in, ack and read data out)
interface mem_arbitro_if #(parameter int AW = 7, parameter int DW = 32);
    logic req, we, wh, ack;
    logic [AW-1:0] dir;
    logic [DW-1:0] di, dout;
    modport master (output req, we, wh, dir, di, input ack, dout);
    modport slave (input req, we, wh, dir, di, output ack, dout);
endinterface

// File: rtl/mem_arbitro.sv
// mem_arbitro: serializes two requester ports onto the single data-memory port
module mem_arbitro #(
    parameter int AW = 7,
    parameter int DW = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          reloj,
    input  logic          reset,
    mem_arbitro_if.slave  port_a,
    mem_arbitro_if.slave  port_b,
    output logic          ocupado,
    output logic [DW-1:0] DI_MEM,
    output logic [AW-1:0] DIR_MEM,
    output logic          MEM_RD,
    output logic          MEM_WR,
    output logic          w_h,
    input  logic [DW-1:0] DO_MEMo
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
    state_t state, state_n;
    logic gnt_b, we_q, wh_q, any_req, pick_b, issue;
    logic [DW-1:0] do_a, do_b;
    assign any_req = port_a.req || port_b.req;
    // gnt_b doubles as last_grant: on a tie the port that was not served last wins
    assign pick_b = (port_a.req && port_b.req) ? (FIXED_PRIO == 0 && !gnt_b) : port_b.req;
    assign issue = state == ISSUE;
    assign {MEM_RD, MEM_WR, w_h} = issue ? (we_q ? {2'b10, wh_q} : 3'b011) : 3'b000;
    assign ocupado = state != IDLE;
    assign port_a.ack = state == ACK && !gnt_b;
    assign port_b.ack = state == ACK && gnt_b;
    assign port_a.dout = do_a;
    assign port_b.dout = do_b;
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (any_req ? ISSUE : IDLE) :
                  state == ISSUE ? (we_q ? ACK : CAPTURE) :
                  state == CAPTURE ? ACK : IDLE;
    end
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt_b <= 1'b1;
            we_q <= 1'b0;
            wh_q <= 1'b0;
            DIR_MEM <= '0;
            DI_MEM <= '0;
            do_a <= '0;
            do_b <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                gnt_b <= pick_b;
                we_q <= pick_b ? port_b.we : port_a.we;
                wh_q <= pick_b ? port_b.wh : port_a.wh;
                DIR_MEM <= pick_b ? port_b.dir : port_a.dir;
                DI_MEM <= pick_b ? port_b.di : port_a.di;
            end
            // memory read data is valid during CAPTURE, one cycle after the read command
            if (state == CAPTURE && gnt_b) do_b <= DO_MEMo;
            if (state == CAPTURE && !gnt_b) do_a <= DO_MEMo;
        end
    end
endmodule

// File: tb/tb_mem_arbitro.sv
// tb_mem_arbitro: directed vectors plus randomized traffic checked against a transaction-level model
module tb_mem_arbitro;
    localparam int AW = 7, DW = 32;
    logic reloj = 1'b0, reset = 1'b1;
    always #5 reloj = ~reloj;

    mem_arbitro_if #(.AW(AW), .DW(DW)) pa(), pb(), pa2(), pb2();
    logic ocupado, MEM_RD, MEM_WR, w_h, ocupado2, rd2, wr2, wh2;
    logic [DW-1:0] DI_MEM, DO_MEMo, di2;
    logic [AW-1:0] DIR_MEM, dir2;

    mem_arbitro #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
        .reloj(reloj), .reset(reset), .port_a(pa), .port_b(pb), .ocupado(ocupado),
        .DI_MEM(DI_MEM), .DIR_MEM(DIR_MEM), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .w_h(w_h),
        .DO_MEMo(DO_MEMo));
    mem_arbitro #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut2 (
        .reloj(reloj), .reset(reset), .port_a(pa2), .port_b(pb2), .ocupado(ocupado2),
        .DI_MEM(di2), .DIR_MEM(dir2), .MEM_RD(rd2), .MEM_WR(wr2), .w_h(wh2),
        .DO_MEMo('0));

    // data memory: registered read, 000 clears the output register
    logic [DW-1:0] mem [128];
    always @(posedge reloj)
        case ({MEM_RD, MEM_WR, w_h})
            3'b011: DO_MEMo <= mem[DIR_MEM];
            3'b101: mem[DIR_MEM] <= DI_MEM;
            3'b100: mem[DIR_MEM] <= {16'h0, DI_MEM[15:0]};
            default: DO_MEMo <= '0;
        endcase

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // reference model: each grant is a transaction of known length, data kept in an array
    int e_n, s_edge, ack_edge, idle_from;
    bit m_b, m_we, m_wh, last_b;
    logic [AW-1:0] m_dir;
    logic [DW-1:0] m_di, m_rd, exp_do_a, exp_do_b;
    logic [DW-1:0] ref_mem [128];
    always @(posedge reloj) begin
        if (reset) begin
            e_n = 0; idle_from = 0; s_edge = -10; ack_edge = -10; last_b = 1'b1;
            exp_do_a = '0; exp_do_b = '0;
        end else begin
            e_n++;
            if (e_n == s_edge + 1) begin
                if (m_we) ref_mem[m_dir] = m_wh ? m_di : {16'h0, m_di[15:0]};
                else m_rd = ref_mem[m_dir];
            end
            if (e_n > idle_from && (pa.req || pb.req)) begin
                m_b = (pa.req && pb.req) ? !last_b : pb.req;
                last_b = m_b;
                m_we = m_b ? pb.we : pa.we;
                m_wh = m_b ? pb.wh : pa.wh;
                m_dir = m_b ? pb.dir : pa.dir;
                m_di = m_b ? pb.di : pa.di;
                s_edge = e_n;
                ack_edge = e_n + (m_we ? 1 : 2);
                idle_from = ack_edge + 1;
            end
            if (e_n == ack_edge && !m_we) begin
                if (m_b) exp_do_b = m_rd;
                else exp_do_a = m_rd;
            end
            #1;
            chk("ack_a", 32'(pa.ack), 32'(e_n == ack_edge && !m_b));
            chk("ack_b", 32'(pb.ack), 32'(e_n == ack_edge && m_b));
            chk("do_a", pa.dout, exp_do_a);
            chk("do_b", pb.dout, exp_do_b);
            chk("ocupado", 32'(ocupado), 32'(e_n >= s_edge && e_n <= ack_edge));
            chk("cmd", 32'({MEM_RD, MEM_WR, w_h}),
                32'(e_n == s_edge ? (m_we ? {2'b10, m_wh} : 3'b011) : 3'b000));
            if (e_n == s_edge) chk("dir_mem", 32'(DIR_MEM), 32'(m_dir));
            if (e_n == s_edge && m_we) chk("di_mem", DI_MEM, m_di);
        end
    end

    task automatic tick;
        @(posedge reloj);
        #1;
    endtask

    task automatic single(input bit b, input bit we, input bit wh, input logic [AW-1:0] dir,
                          input logic [DW-1:0] di, output int lat, output logic [DW-1:0] dout);
        if (b) begin pb.we = we; pb.wh = wh; pb.dir = dir; pb.di = di; pb.req = 1'b1; end
        else begin pa.we = we; pa.wh = wh; pa.dir = dir; pa.di = di; pa.req = 1'b1; end
        lat = 0;
        dout = '0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick;
            if (b ? pb.ack : pa.ack) begin lat = i; dout = b ? pb.dout : pa.dout; end
        end
        pa.req = 1'b0;
        pb.req = 1'b0;
        tick;
    endtask

    task automatic pair(input bit wea, input logic [AW-1:0] dira, input logic [DW-1:0] dia,
                        input bit web, input logic [AW-1:0] dirb, input logic [DW-1:0] dib,
                        output bit first_b, output logic [DW-1:0] oa, output logic [DW-1:0] ob);
        bit got_a, got_b;
        got_a = 1'b0; got_b = 1'b0; first_b = 1'b1; oa = '0; ob = '0;
        pa.we = wea; pa.wh = 1'b1; pa.dir = dira; pa.di = dia; pa.req = 1'b1;
        pb.we = web; pb.wh = 1'b1; pb.dir = dirb; pb.di = dib; pb.req = 1'b1;
        for (int i = 0; i < 20 && !(got_a && got_b); i++) begin
            tick;
            if (pa.ack && !got_a) begin
                if (!got_b) first_b = 1'b0;
                got_a = 1'b1; oa = pa.dout; pa.req = 1'b0;
            end
            if (pb.ack && !got_b) begin got_b = 1'b1; pb.req = 1'b0; end
        end
        ob = pb.dout;
        chk("pair_both_acked", 32'({got_a, got_b}), 32'(2'b11));
        tick;
    endtask

    typedef struct {
        bit b; bit we; bit wh;
        logic [AW-1:0] dir;
        logic [DW-1:0] di;
        int lat;
        logic [DW-1:0] exp_do;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int lat, na, hits;
        bit fb, done;
        logic [DW-1:0] d, oa, ob;
        for (int i = 0; i < 128; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[16] = 32'h0BAD0010;
        ref_mem[16] = 32'h0BAD0010;
        DO_MEMo = '0;
        pa.req = 0; pa.we = 0; pa.wh = 0; pa.dir = '0; pa.di = '0;
        pb.req = 0; pb.we = 0; pb.wh = 0; pb.dir = '0; pb.di = '0;
        pa2.req = 0; pa2.we = 1; pa2.wh = 1; pa2.dir = 7'h01; pa2.di = 32'h1;
        pb2.req = 0; pb2.we = 1; pb2.wh = 1; pb2.dir = 7'h02; pb2.di = 32'h2;
        vecs[0] = '{0, 1, 1, 7'h05, 32'hDEADBEEF, 2, 32'h0};
        vecs[1] = '{0, 0, 0, 7'h05, 32'h0, 3, 32'hDEADBEEF};
        vecs[2] = '{1, 1, 0, 7'h7F, 32'h1234ABCD, 2, 32'h0};
        vecs[3] = '{1, 0, 0, 7'h7F, 32'h0, 3, 32'h0000ABCD};
        vecs[4] = '{0, 1, 0, 7'h00, 32'hFFFF0001, 2, 32'h0};
        vecs[5] = '{0, 0, 1, 7'h00, 32'h0, 3, 32'h00000001};
        vecs[6] = '{1, 0, 1, 7'h05, 32'h0, 3, 32'hDEADBEEF};
        vecs[7] = '{0, 0, 0, 7'h7F, 32'h0, 3, 32'h0000ABCD};
        repeat (2) @(posedge reloj);
        #1 reset = 1'b0;

        // same-cycle read (A) and write (B) to one address: A wins the first tie
        pair(1'b0, 7'h10, 32'h0, 1'b1, 7'h10, 32'hCAFEF00D, fb, oa, ob);
        chk("rr_first_tie_a", 32'(fb), 32'(1'b0));
        chk("race_read_old", oa, 32'h0BAD0010);
        chk("race_do_b_kept", ob, 32'h0);
        single(1'b0, 1'b0, 1'b0, 7'h10, 32'h0, lat, d);
        chk("race_read_new", d, 32'hCAFEF00D);

        foreach (vecs[i]) begin
            single(vecs[i].b, vecs[i].we, vecs[i].wh, vecs[i].dir, vecs[i].di, lat, d);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            if (!vecs[i].we) chk($sformatf("vec%0d_do", i), d, vecs[i].exp_do);
        end

        // reset in the middle of an ISSUE cycle abandons the write
        pa.we = 1; pa.wh = 1; pa.dir = 7'h30; pa.di = 32'h5555AAAA; pa.req = 1'b1;
        @(posedge reloj);
        #2 reset = 1'b1;
        #1;
        chk("rst_cmd", 32'({MEM_RD, MEM_WR, w_h}), 32'(3'b000));
        chk("rst_ack", 32'({pa.ack, pb.ack}), 32'(2'b00));
        chk("rst_do_a", pa.dout, 32'h0);
        chk("rst_do_b", pb.dout, 32'h0);
        chk("rst_ocupado", 32'(ocupado), 32'(1'b0));
        pa.req = 1'b0;
        tick;
        reset = 1'b0;
        single(1'b0, 1'b0, 1'b0, 7'h30, 32'h0, lat, d);
        chk("rst_write_dropped", d, 32'h0);

        // address is latched at grant; a req held past ack is a second request
        pa.we = 0; pa.wh = 0; pa.dir = 7'h05; pa.di = '0; pa.req = 1'b1;
        tick;
        tick;
        pa.dir = 7'h7F;
        hits = 0;
        for (int i = 0; i < 14 && hits < 2; i++) begin
            tick;
            if (pa.ack) begin
                hits++;
                chk(hits == 1 ? "latched_dir" : "second_access", pa.dout,
                    hits == 1 ? 32'hDEADBEEF : 32'h0000ABCD);
                if (hits == 2) pa.req = 1'b0;
            end
        end
        chk("second_access_count", 32'(hits), 32'd2);
        tick;

        single(1'b1, 1'b1, 1'b1, 7'h20, 32'h11112222, lat, d);
        for (int r = 0; r < 3; r++) begin
            pair(1'b1, 7'(8'h40 + r), 32'(r), 1'b1, 7'(8'h50 + r), 32'(r + 100), fb, oa, ob);
            chk($sformatf("rr_round%0d_a_first", r), 32'(fb), 32'(1'b0));
        end

        // fixed priority: A keeps winning while held, B only after A drops
        pa2.req = 1'b1;
        pb2.req = 1'b1;
        na = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick;
            if (pa2.ack) begin
                na++;
                if (na == 3) pa2.req = 1'b0;
            end
            if (pb2.ack) begin
                chk("fixed_a_grants_before_b", 32'(na), 32'd3);
                pb2.req = 1'b0;
                done = 1'b1;
            end
        end
        chk("fixed_b_served", 32'(done), 32'(1'b1));

        for (int c = 0; c < 800; c++) begin
            tick;
            if (pa.ack || !pa.req) begin
                pa.req = $urandom_range(0, 2) != 0;
                pa.we = 1'($urandom_range(0, 1)); pa.wh = 1'($urandom_range(0, 1));
                pa.dir = 7'($urandom_range(0, 15)); pa.di = $urandom;
            end
            if (pb.ack || !pb.req) begin
                pb.req = $urandom_range(0, 2) != 0;
                pb.we = 1'($urandom_range(0, 1)); pb.wh = 1'($urandom_range(0, 1));
                pb.dir = 7'($urandom_range(0, 15)); pb.di = $urandom;
            end
        end
        pa.req = 1'b0;
        pb.req = 1'b0;
        repeat (6) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
